// File: rtl/instr_issue.sv
// -----------------------------------------------------------------------------
// instr_issue
//   Sits upstream of the control FSM. Buffers 16-bit instructions in a small
//   FIFO and holds the instruction being executed in the instruction register
//   (IR). It starts the controller with a one-cycle s pulse and keeps IR
//   stable until the controller signals completion with w. It also decodes IR
//   fields and maps the controller's one-hot nsel onto the register-file
//   readnum/writenum ports.
//
//   Optional feature macro: ISSUE_ILLEGAL_TRAP_EN
//     When defined, popped words whose {opcode,op} is not legal are dropped
//     rather than issued, and the sticky err_illegal output is raised.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   in_valid  in   producer offers in_instr
//   in_instr  in   16-bit instruction word
//   in_ready  out  FIFO can accept a word (not full)
//   w         in   controller completion pulse
//   nsel      in   controller one-hot select {Rn,Rd,Rm}
//   s         out  one-cycle start pulse to the controller
//   opcode    out  IR[15:13]
//   op        out  IR[12:11]
//   ALUop     out  IR[12:11]
//   shift     out  IR[4:3]
//   sximm8    out  sign-extended IR[7:0]
//   sximm5    out  sign-extended IR[4:0]
//   readnum   out  register number selected by nsel
//   writenum  out  register number selected by nsel
//   busy      out  an instruction is starting or executing
//   fifo_cnt  out  FIFO occupancy 0..DEPTH
//   err_illegal out (ISSUE_ILLEGAL_TRAP_EN only) sticky illegal-word flag
// -----------------------------------------------------------------------------
module instr_issue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    input  logic          w,
    input  logic [2:0]    nsel,
    output logic          s,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [15:0]   sximm8,
    output logic [15:0]   sximm5,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          busy,
`ifdef ISSUE_ILLEGAL_TRAP_EN
    output logic          err_illegal,
`endif
    output logic [AW:0]   fifo_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    state_t          state_reg, state_next;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wptr_reg, rptr_reg;
    logic [AW:0]     cnt_reg;
    logic [15:0]     ir_reg;
    logic [15:0]     head;
    logic            full, push, pop_en, head_legal, load_ir;
    logic [2:0]      regsel;

    assign full     = (cnt_reg == FULL_CNT);
    assign in_ready = ~full;
    // Acceptance depends only on full; a same-cycle pop never frees a slot early.
    assign push     = in_valid & ~full;
    assign head     = mem[rptr_reg];
    assign pop_en   = ((state_reg == S_IDLE) | ((state_reg == S_EXEC) & w))
                      & (cnt_reg != '0);

`ifdef ISSUE_ILLEGAL_TRAP_EN
    assign head_legal = ((head[15:13] == 3'b110) &
                         ((head[12:11] == 2'b10) | (head[12:11] == 2'b00)))
                      | (head[15:13] == 3'b101);
`else
    assign head_legal = 1'b1;
`endif

    // A popped word is only loaded into IR (and issued) when legal; an illegal
    // word is consumed from the FIFO and discarded.
    assign load_ir = pop_en & head_legal;

    // FIFO storage: no reset, contents are qualified by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            cnt_reg   <= '0;
            ir_reg    <= 16'h0000;
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_en) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            if (load_ir) begin
                ir_reg <= head;
            end
            case ({push, pop_en})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

`ifdef ISSUE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
        end else if (pop_en & ~head_legal) begin
            err_illegal <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (load_ir) state_next = S_START;
            S_START: state_next = S_EXEC;
            // On completion either issue the next word back-to-back or go
            // idle (also when the next word was dropped as illegal).
            S_EXEC:  if (w) state_next = load_ir ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign s        = (state_reg == S_START);
    assign busy     = (state_reg != S_IDLE);
    assign fifo_cnt = cnt_reg;

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign ALUop  = ir_reg[12:11];
    assign shift  = ir_reg[4:3];
    assign sximm8 = {{8{ir_reg[7]}}, ir_reg[7:0]};
    assign sximm5 = {{11{ir_reg[4]}}, ir_reg[4:0]};

    always_comb begin
        regsel = 3'b000;
        case (nsel)
            3'b100:  regsel = ir_reg[10:8];
            3'b010:  regsel = ir_reg[7:5];
            3'b001:  regsel = ir_reg[2:0];
            default: regsel = 3'b000;
        endcase
    end

    assign readnum  = regsel;
    assign writenum = regsel;

endmodule
